i2c_slave_responder: RTL and testbench

- I2C target (responder) for the other end of the existing I2C config master's bus.
- Decodes START/STOP, matches a 7-bit device address and receives a 1- or 2-byte register address.
- Exposes register writes and reads as single-cycle strobes on a local register port.
- Used as an on-chip peripheral-config target and as the bench model for codec configuration traffic.

---
 rtl/i2c_slave_pkg.sv | 28 ++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_slave_responder.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C responder.
// State encoding, bit counter width and ACK/NACK line levels.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        ADDR_H,
        ADDR_L,
        ACK_ADDR,
        WR_DATA,
        ACK_WR,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 4'd7;
    localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
// Both lines share one pipeline so their events stay aligned.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] scl_pipe;
    logic [N-1:0] sda_pipe;
    logic         scl_q;
    logic         sda_q;
    logic         scl_s;

    // Idle bus is high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[N-2:0], scl_i};
            sda_pipe <= {sda_pipe[N-2:0], sda_i};
            scl_q    <= scl_pipe[N-1];
            sda_q    <= sda_pipe[N-1];
        end
    end

    assign scl_s = scl_pipe[N-1];
    assign sda_s = sda_pipe[N-1];

    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, register pointer, and single-cycle
// write/read strobes onto a local register port.
module i2c_slave_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         ADDR_2BYTE  = 0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oen,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        error
);

    import i2c_slave_pkg::*;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    state_t state;
    state_t state_n;

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [6:0]           shift;
    logic [7:0]           tx;
    logic [7:0]           rx_byte;
    logic                 rw;
    logic                 addr_hi;
    logic                 ld_phase;
    logic                 byte_done;
    logic                 addr_match;
    logic                 ack_held;
    logic                 rx_state;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    assign rx_byte    = {shift, sda_s};
    assign byte_done  = scl_rise && (bit_cnt == LAST_BIT);
    assign addr_match = (shift == DEV_ADDR);
    assign ack_held   = (sda_oen == ACK);
    assign rx_state   = (state == i2c_slave_pkg::DEV_ADDR) ||
                        (state == ADDR_H) ||
                        (state == ADDR_L) ||
                        (state == WR_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Reads leave ACK_DEV/RD_ACK on the 9th rise so the load
    // finishes before the fall that must present bit 7.
    always_comb begin
        state_n = state;
        if (stop_det) begin
            state_n = IDLE;
        end else if (start_det) begin
            state_n = i2c_slave_pkg::DEV_ADDR;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                i2c_slave_pkg::DEV_ADDR:
                    if (byte_done)
                        state_n = addr_match ? ACK_DEV : IDLE;
                ACK_DEV:
                    if (ack_held && rw && scl_rise)
                        state_n = RD_LOAD;
                    else if (ack_held && !rw && scl_fall)
                        state_n = (ADDR_2BYTE != 0) ? ADDR_H : ADDR_L;
                ADDR_H, ADDR_L:
                    if (byte_done)
                        state_n = ACK_ADDR;
                ACK_ADDR:
                    if (ack_held && scl_fall)
                        state_n = addr_hi ? ADDR_L : WR_DATA;
                WR_DATA:
                    if (byte_done)
                        state_n = ACK_WR;
                ACK_WR:
                    if (ack_held && scl_fall)
                        state_n = WR_DATA;
                RD_LOAD:
                    if (ld_phase)
                        state_n = RD_DATA;
                RD_DATA:
                    if (scl_fall && bit_cnt == BYTE_BITS)
                        state_n = RD_ACK;
                RD_ACK:
                    if (scl_rise)
                        state_n = (sda_s == NACK) ? WAIT_STOP : RD_LOAD;
                WAIT_STOP: state_n = WAIT_STOP;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift     <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            addr_hi   <= 1'b0;
            ld_phase  <= 1'b0;
            sda_oen   <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;

            if (scl_rise)
                shift <= {shift[5:0], sda_s};

            if (start_det || stop_det || state_n != state)
                bit_cnt <= '0;
            else if (scl_rise && rx_state)
                bit_cnt <= bit_cnt + 1'b1;
            else if (scl_fall && state == RD_DATA)
                bit_cnt <= bit_cnt + 1'b1;

            if (stop_det) begin
                sda_oen <= 1'b1;
                busy    <= 1'b0;
                if (state == RD_DATA || state == RD_LOAD)
                    error <= 1'b1;
            end else if (start_det) begin
                sda_oen <= 1'b1;
                error   <= 1'b0;
            end else begin
                case (state)
                    i2c_slave_pkg::DEV_ADDR:
                        if (byte_done) begin
                            rw <= sda_s;
                            if (addr_match)
                                busy <= 1'b1;
                        end
                    ACK_DEV, ACK_ADDR, ACK_WR:
                        if (scl_fall) begin
                            sda_oen <= ~sda_oen;
                            if (state == ACK_WR && ack_held)
                                reg_addr <= reg_addr + 16'd1;
                        end
                    ADDR_H:
                        if (byte_done) begin
                            reg_addr[15:8] <= rx_byte;
                            addr_hi        <= 1'b1;
                        end
                    ADDR_L:
                        if (byte_done) begin
                            reg_addr[7:0] <= rx_byte;
                            if (ADDR_2BYTE == 0)
                                reg_addr[15:8] <= 8'h00;
                            addr_hi <= 1'b0;
                        end
                    WR_DATA:
                        if (byte_done) begin
                            reg_wdata <= rx_byte;
                            reg_wr    <= 1'b1;
                        end
                    RD_LOAD: begin
                        ld_phase <= 1'b1;
                        if (ld_phase)
                            tx <= reg_rdata;
                    end
                    RD_DATA:
                        if (scl_fall) begin
                            if (bit_cnt == BYTE_BITS) begin
                                sda_oen <= 1'b1;
                            end else begin
                                sda_oen <= tx[7];
                                tx      <= {tx[6:0], 1'b0};
                            end
                        end
                    RD_ACK:
                        if (scl_rise && sda_s == ACK)
                            reg_addr <= reg_addr + 16'd1;
                    default: ;
                endcase

                if (state_n == RD_LOAD && state != RD_LOAD) begin
                    reg_rd   <= 1'b1;
                    ld_phase <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against two responders
// (1-byte and 2-byte register address) with a small register model.
module tb_i2c_slave_responder;

    import i2c_slave_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        sel;
    logic        sda_line;
    logic        scl0, sda0, scl1, sda1;
    logic        oen0, oen1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  rdata0, rdata1;
    logic        wr0, wr1, rd0, rd1;
    logic        busy0, busy1, err0, err1;

    int checks = 0;
    int errors = 0;
    int rd_cnt0 = 0;
    int low_cnt0 = 0;
    int both_cnt = 0;

    logic [23:0] wq0[$];
    logic [23:0] wq1[$];

    logic        a0, a1, a2, a3, a4, b;
    logic [7:0]  d0, d1;
    int          n0, n1, r0, l0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & (sel ? oen1 : oen0);
    assign scl0 = sel ? 1'b1 : scl_m;
    assign sda0 = sel ? 1'b1 : sda_line;
    assign scl1 = sel ? scl_m : 1'b1;
    assign sda1 = sel ? sda_line : 1'b1;

    i2c_slave_responder #(
        .DEV_ADDR(7'h1A), .ADDR_2BYTE(0), .SYNC_STAGES(2)
    ) dut0 (
        .clk(clk), .rst(rst), .scl_i(scl0), .sda_i(sda0),
        .sda_oen(oen0), .reg_addr(addr0), .reg_wdata(wdata0),
        .reg_wr(wr0), .reg_rd(rd0), .reg_rdata(rdata0),
        .busy(busy0), .error(err0)
    );

    i2c_slave_responder #(
        .DEV_ADDR(7'h1A), .ADDR_2BYTE(1), .SYNC_STAGES(2)
    ) dut1 (
        .clk(clk), .rst(rst), .scl_i(scl1), .sda_i(sda1),
        .sda_oen(oen1), .reg_addr(addr1), .reg_wdata(wdata1),
        .reg_wr(wr1), .reg_rd(rd1), .reg_rdata(rdata1),
        .busy(busy1), .error(err1)
    );

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'd5:   return 8'h5A;
            16'd6:   return 8'h3C;
            default: return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rd0) rdata0 <= rom(addr0);
        if (rd1) rdata1 <= rom(addr1);
        if (wr0) wq0.push_back({addr0, wdata0});
        if (wr1) wq1.push_back({addr1, wdata1});
        if (rd0) rd_cnt0++;
        if (!oen0) low_cnt0++;
        if ((wr0 && rd0) || (wr1 && rd1)) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic v);
        sda_m = v;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic v);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        v = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            d[i] = v;
        end
        send_bit(nack);
    endtask

    function automatic logic [23:0] wq_at(input int q, input int i);
        if (q == 0) return (wq0.size() > i) ? wq0[i] : 24'hFFFFFF;
        return (wq1.size() > i) ? wq1[i] : 24'hFFFFFF;
    endfunction

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oen", 32'(oen0), 32'd1);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_wdata", 32'(wdata0), 32'd0);
        chk("rst_strobes", 32'({wr0, rd0}), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_dut1", 32'({oen1, busy1, err1}), 32'b100);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single write, 1-byte address
        n0 = wq0.size();
        start_cond();
        write_byte(8'h34, a0);
        write_byte(8'h07, a1);
        write_byte(8'h0A, a2);
        chk("w1_acks", 32'({a0, a1, a2}), 32'd0);
        chk("w1_busy_on", 32'(busy0), 32'd1);
        stop_cond();
        chk("w1_count", 32'(wq0.size() - n0), 32'd1);
        chk("w1_strobe", 32'(wq_at(0, n0)), 32'h00070A);
        chk("w1_addr_inc", 32'(addr0), 32'h0008);
        chk("w1_busy_off", 32'(busy0), 32'd0);

        // burst write, 2-byte address
        sel = 1'b1;
        repeat (10) @(negedge clk);
        n1 = wq1.size();
        start_cond();
        write_byte(8'h34, a0);
        write_byte(8'h12, a1);
        write_byte(8'h34, a2);
        write_byte(8'hAA, a3);
        write_byte(8'hBB, a4);
        stop_cond();
        chk("w2_acks", 32'({a0, a1, a2, a3, a4}), 32'd0);
        chk("w2_count", 32'(wq1.size() - n1), 32'd2);
        chk("w2_strobe0", 32'(wq_at(1, n1)), 32'h1234AA);
        chk("w2_strobe1", 32'(wq_at(1, n1 + 1)), 32'h1235BB);
        chk("w2_busy_off", 32'(busy1), 32'd0);
        sel = 1'b0;
        repeat (10) @(negedge clk);

        // random read: pointer write, repeated START, two bytes
        r0 = rd_cnt0;
        start_cond();
        write_byte(8'h34, a0);
        write_byte(8'h05, a1);
        start_cond();
        write_byte(8'h35, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        stop_cond();
        chk("rd_acks", 32'({a0, a1, a2}), 32'd0);
        chk("rd_byte0", 32'(d0), 32'h5A);
        chk("rd_byte1", 32'(d1), 32'h3C);
        chk("rd_count", 32'(rd_cnt0 - r0), 32'd2);
        chk("rd_err", 32'(err0), 32'd0);
        chk("rd_addr", 32'(addr0), 32'h0006);

        // address mismatch
        n0 = wq0.size();
        l0 = low_cnt0;
        start_cond();
        write_byte(8'h40, a0);
        write_byte(8'h01, a1);
        stop_cond();
        chk("mm_nacks", 32'({a0, a1}), 32'b11);
        chk("mm_oen_low", 32'(low_cnt0 - l0), 32'd0);
        chk("mm_count", 32'(wq0.size() - n0), 32'd0);
        chk("mm_busy", 32'(busy0), 32'd0);

        // STOP after 4 data bits
        n0 = wq0.size();
        start_cond();
        write_byte(8'h34, a0);
        write_byte(8'h07, a1);
        send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0);
        stop_cond();
        chk("ab_wr_count", 32'(wq0.size() - n0), 32'd0);
        chk("ab_wr_state", 32'(dut0.state), 32'(IDLE));
        chk("ab_wr_addr", 32'(addr0), 32'h0007);

        // STOP in the middle of a read byte
        start_cond();
        write_byte(8'h34, a0);
        write_byte(8'h05, a1);
        start_cond();
        write_byte(8'h35, a2);
        recv_bit(b); recv_bit(b); recv_bit(b);
        stop_cond();
        chk("ab_rd_err", 32'(err0), 32'd1);
        chk("ab_rd_busy", 32'(busy0), 32'd0);
        start_cond();
        chk("ab_rd_clr", 32'(err0), 32'd0);
        stop_cond();

        // reset during the device-address ACK
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(logic'(8'h34 >> i));
        chk("rs_ack_drv", 32'(oen0), 32'd0);
        rst = 1'b1;
        #1;
        chk("rs_oen", 32'(oen0), 32'd1);
        chk("rs_outs", 32'({addr0, wdata0, wr0, rd0, busy0, err0}),
            32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        stop_cond();
        n0 = wq0.size();
        start_cond();
        write_byte(8'h34, a0);
        write_byte(8'h20, a1);
        write_byte(8'h55, a2);
        stop_cond();
        chk("rs_acks", 32'({a0, a1, a2}), 32'd0);
        chk("rs_strobe", 32'(wq_at(0, n0)), 32'h002055);
        chk("rs_addr", 32'(addr0), 32'h0021);

        chk("wr_rd_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
